// File: rtl/serial_subtractor8.sv
// Bit-serial subtractor: diff = a - b - b_in, one bit per clock, LSB first.
// The result and flags are registered and held until the next operation completes.
module serial_subtractor8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             overflow,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_SUB, S_DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a, r_b, r_res;
    logic             r_br, r_amsb, r_bmsb;
    logic [CW-1:0]    r_cnt;
    logic             r_busy, r_done, r_bout, r_ovf, r_zero;
    logic [WIDTH-1:0] r_diff;

    logic             w_ai, w_bi, w_d, w_br_nxt, w_last;
    logic [WIDTH-1:0] w_res;

    assign w_ai     = r_a[0];
    assign w_bi     = r_b[0];
    assign w_d      = w_ai ^ w_bi ^ r_br;
    assign w_br_nxt = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
    // New bit enters at the MSB; after WIDTH shifts bit 0 has reached position 0.
    assign w_res    = {w_d, r_res[WIDTH-1:1]};
    assign w_last   = (r_cnt == CW'(WIDTH-1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_amsb  <= 1'b0;
            r_bmsb  <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= b_in;
                        r_amsb  <= a[WIDTH-1];
                        r_bmsb  <= b[WIDTH-1];
                        r_cnt   <= '0;
                        r_res   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SUB;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SUB: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br_nxt;
                    r_res <= w_res;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_diff  <= w_res;
                        r_bout  <= w_br_nxt;
                        r_ovf   <= (r_amsb != r_bmsb) & (w_d != r_amsb);
                        r_zero  <= (w_res == '0);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign diff     = r_diff;
    assign b_out    = r_bout;
    assign overflow = r_ovf;
    assign zero     = r_zero;
endmodule

// File: tb/tb_serial_subtractor8.sv
// Self-checking bench for serial_subtractor8: directed corners plus random
// operands compared against an arithmetic reference model.
module tb_serial_subtractor8;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, b_in;
    logic [W-1:0] a, b;
    logic         busy, done, b_out, overflow, zero;
    logic [W-1:0] diff;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_prev = '0;

    serial_subtractor8 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .b_in(b_in),
        .busy(busy), .done(done), .diff(diff), .b_out(b_out),
        .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive a request; called at a negedge.
    task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
        a = ia; b = ib; b_in = ibin; start = 1'b1;
    endtask

    // Wait out one accepted operation and check handshake timing and results.
    // If chain is set, the next request is driven during the DONE cycle.
    task automatic wait_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                           input bit mid_start, input bit chain,
                           input logic [W-1:0] na, input logic [W-1:0] nb, input logic nbin);
        int full, bcnt;
        logic [W-1:0] ed;
        logic eb, eo, ez;
        bit got;
        full = int'(ia) - int'(ib) - int'(ibin);
        ed   = W'(full & ((1 << W) - 1));
        eb   = (full < 0);
        eo   = (ia[W-1] != ib[W-1]) && (ed[W-1] != ia[W-1]);
        ez   = (ed == '0);
        bcnt = 0;
        got  = 1'b0;
        @(posedge clk);
        for (int n = 1; n <= W + 4 && !got; n++) begin
            @(negedge clk);
            if (busy && done) chk("busy_done_excl", 1, 0);
            if (done) begin
                got = 1'b1;
                chk("latency", n, W + 1);
                chk("busy_cycles", bcnt, W);
                chk("diff", diff, ed);
                chk("b_out", b_out, eb);
                chk("overflow", overflow, eo);
                chk("zero", zero, ez);
                exp_prev = ed;
                if (chain) start_op(na, nb, nbin);
            end else begin
                if (busy) bcnt++;
                if (n <= W && diff !== exp_prev) chk("diff_hold", diff, exp_prev);
            end
            if (n == 1) begin
                start = 1'b0;
                a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
            end
            if (mid_start && n == 3) begin
                start = 1'b1; a = W'($urandom); b = W'($urandom);
            end
            if (mid_start && n == 4) start = 1'b0;
        end
        if (!got) chk("done_timeout", 0, 1);
    endtask

    task automatic run(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin, input bit mid);
        start_op(ia, ib, ibin);
        wait_op(ia, ib, ibin, mid, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        logic [W-1:0] ca, cb, xa, xb;
        logic cbin, xbin;
        bit ch;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_diff", diff, 0);
        chk("rst_bout", b_out, 0); chk("rst_ovf", overflow, 0); chk("rst_zero", zero, 0);
        rst = 1'b0;
        @(negedge clk);

        run(8'h50, 8'h20, 1'b0, 1'b0);
        run(8'h00, 8'h01, 1'b0, 1'b0);
        run(8'h80, 8'h01, 1'b0, 1'b0);
        run(8'h7F, 8'hFF, 1'b0, 1'b0);
        run(8'h05, 8'h04, 1'b1, 1'b0);
        run(8'h00, 8'hFF, 1'b1, 1'b0);
        run(8'h80, 8'h00, 1'b1, 1'b0);
        // start pulsed again mid-operation must be ignored
        run(8'h33, 8'h11, 1'b0, 1'b1);
        // back-to-back via start held in DONE
        start_op(8'h10, 8'h20, 1'b0);
        wait_op(8'h10, 8'h20, 1'b0, 1'b0, 1'b1, 8'hC3, 8'h3C, 1'b1);
        wait_op(8'hC3, 8'h3C, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);

        // reset 4 cycles into SUB aborts the operation
        start_op(8'h99, 8'h11, 1'b0);
        @(posedge clk);
        repeat (4) @(negedge clk);
        start = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0); chk("abort_done", done, 0); chk("abort_diff", diff, 0);
        chk("abort_bout", b_out, 0); chk("abort_ovf", overflow, 0); chk("abort_zero", zero, 0);
        exp_prev = '0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            if (done || busy) chk("abort_quiet", {busy, done}, 0);
        end
        // reset and start on the same edge: request dropped
        start_op(8'h44, 8'h01, 1'b0); rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", busy, 0);
        run(8'hA5, 8'h5A, 1'b1, 1'b0);

        ca = W'($urandom); cb = W'($urandom); cbin = 1'($urandom);
        start_op(ca, cb, cbin);
        for (int i = 0; i < 1000; i++) begin
            xa = W'($urandom); xb = W'($urandom); xbin = 1'($urandom);
            ch = (i != 999) && ($urandom_range(0, 3) == 0);
            wait_op(ca, cb, cbin, ($urandom_range(0, 7) == 0), ch, xa, xb, xbin);
            if (!ch && i != 999) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                start_op(xa, xb, xbin);
            end
            ca = xa; cb = xb; cbin = xbin;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_subtractor8.md
# serial_subtractor8

Sequential 8-bit subtractor computing `diff = a - b - b_in` bit-serially, LSB first, one bit per clock, under a start/done handshake. It is the inverse-direction companion to the team's ripple full-adder blocks. It gives datapaths that cannot afford a combinational 8-bit borrow chain a small, multi-cycle subtract unit with borrow, signed-overflow and zero flags.

## Interface
- `WIDTH`, default 8: operand width; the design and tests target 8, and any value ≥ 2 must elaborate.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request; sampled only while the unit is idle or in DONE.
- `a`  in  WIDTH: minuend; captured on the accepting edge.
- `b`  in  WIDTH: subtrahend; captured on the accepting edge.
- `b_in`  in  1: borrow in; captured on the accepting edge.
- `busy`  out  1: high while bits are being processed.
- `done`  out  1: one-cycle pulse when a result becomes valid.
- `diff`  out  WIDTH: result; held until the next result.
- `b_out`  out  1: borrow out; 1 iff unsigned `a < b + b_in`.
- `overflow`  out  1: two's-complement overflow of the subtraction.
- `zero`  out  1: 1 iff `diff == 0`.

## Operation
- **States:** IDLE, SUB, DONE.
- **IDLE:**
  - `start=1` → capture `a`, `b` and `b_in` into shift registers; clear the bit counter; go to SUB.
  - Otherwise stay in IDLE.
- **SUB:** each edge processes bit i = counter.
  - `d_i = a_i ^ b_i ^ br`
  - `br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)`, where `br` is initialised from `b_in`.
  - Shift `d_i` into the result shift register; increment the counter.
  - After bit WIDTH-1 is processed: go to DONE and load `diff`, `b_out`, `overflow` and `zero` from the final values.
- **Flags:**
  - `overflow = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB])`, using the captured operands.
  - `b_in` does not enter the overflow formula except through `diff`.
- **DONE:** lasts one cycle.
  - `start=1` → accept new operands immediately (back-to-back) and go to SUB.
  - Otherwise go to IDLE.
- **Result behaviour:**
  - Result outputs change only on the edge entering DONE.
  - During SUB they hold the previous result.
- **Ignored requests:** `start` while in SUB is ignored; it is neither queued nor allowed to corrupt the operation.
- **Operand stability:** input changes after the accepting edge have no effect.
- **Width rule:** the result equals `(a + ~b + ~b_in) mod 2^WIDTH`, and `b_out` is the inverse of that sum's carry-out.

## Timing
- **Reset:**
  - State goes to IDLE.
  - `busy=0`, `done=0`, `diff=0`, `b_out=0`, `overflow=0`, `zero=0`.
  - Counter and shift registers are cleared.
- **Acceptance and latency:** let the accepting edge be E.
  - `busy=1` in the WIDTH cycles following E.
  - `done=1` in the single cycle after edge E+WIDTH, with results valid in that same cycle.
  - Total latency from the start edge to `done` is WIDTH+1 edges (9 for 8 bits).
- **Throughput:** back-to-back operation gives one result per WIDTH+1 cycles.
- **Exclusivity:** `busy` and `done` are never high together.
- **Reset mid-operation:**
  - Takes priority over everything.
  - The operation is aborted, no `done` is produced and all outputs are cleared on that edge.
- **Reset and start together:** reset wins; the request is dropped.

## Test plan
- **Basic subtract:** `a=0x50`, `b=0x20`, `b_in=0`, `start` pulsed → `busy` high for 8 cycles, then `done` for 1 cycle with `diff=0x30`, `b_out=0`, `overflow=0`, `zero=0`.
- **Unsigned wrap:** `a=0x00`, `b=0x01`, `b_in=0` → `diff=0xFF`, `b_out=1`, `overflow=0`, `zero=0`.
- **Signed overflow:** `a=0x80`, `b=0x01`, `b_in=0` → `diff=0x7F`, `b_out=0`, `overflow=1`. Then `a=0x7F`, `b=0xFF` → `diff=0x80`, `b_out=1`, `overflow=1`.
- **Borrow-in to zero:** `a=0x05`, `b=0x04`, `b_in=1` → `diff=0x00`, `zero=1`, `b_out=0`. Also `a=0x00`, `b=0xFF`, `b_in=1` → `diff=0x00`, `b_out=1`, `zero=1`.
- **Handshake corners:**
  - `start` re-asserted with different operands during SUB → ignored; the original result is delivered.
  - `start` held high in the DONE cycle → second operation begins; its `done` arrives 9 cycles later.
  - `diff` holds its old value throughout SUB.
- **Reset abort, then random check:**
  - `rst` pulsed 4 cycles into SUB → `done` never asserts and all outputs are 0 on the next cycle; a following request still completes correctly.
  - Then 1000 random `(a, b, b_in)` triples checked against `(a - b - b_in) mod 256` and the flag formulas.
